// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU accumulator stage
//
// Contents:
//   state_t    : key debouncer FSM states (IDLE, CAPTURE, HOLD)
//   DATA_W     : accumulator / ALU result width (8)
//   HIST_DEPTH : number of history entries (4)
//   hist_idx_t : history read index (2 bits)
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam int DATA_W     = 8;
  localparam int HIST_DEPTH = 4;

  typedef logic [1:0] hist_idx_t;

endpackage

// File: rtl/alu_acc_stage_if.sv
// rtl/alu_acc_stage_if.sv - signal bundle between the accumulator stage and its surroundings
//
// Signals:
//   capture_key   : raw active-low pushbutton (asynchronous)
//   alu_in        : ALU result to capture
//   hist_sel      : history read index, 0 = most recent previous value
//   acc_out       : accumulator value, [3:0] is ALU operand B
//   capture_pulse : one-cycle strobe in the cycle the accumulator is written
//   hist_out      : selected history entry, zero when hist_sel >= hist_count
//   hist_count    : number of valid history entries, 0..4
// Modports: master (board/ALU side), slave (accumulator stage)
interface alu_acc_stage_if;
  import alu_pkg::*;

  logic              capture_key;
  logic [DATA_W-1:0] alu_in;
  hist_idx_t         hist_sel;
  logic [DATA_W-1:0] acc_out;
  logic              capture_pulse;
  logic [DATA_W-1:0] hist_out;
  logic [2:0]        hist_count;

  modport master (
    output capture_key, alu_in, hist_sel,
    input  acc_out, capture_pulse, hist_out, hist_count
  );

  modport slave (
    input  capture_key, alu_in, hist_sel,
    output acc_out, capture_pulse, hist_out, hist_count
  );

endinterface

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - synchroniser, debounce counter and press FSM for the capture key
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable synchronised samples to accept a press or release (>= 1)
// Ports:
//   clock         : system clock, rising edge
//   reset_n       : asynchronous active-low reset
//   key_n         : raw active-low pushbutton, asynchronous to clock
//   capture_pulse : registered, high for exactly the CAPTURE cycle
//   state         : current FSM state
module key_debouncer
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   key_n,
  output logic   capture_pulse,
  output state_t state
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          key_s;
  logic [CW-1:0] cnt;

  // Both flops reset to the released level so a held key is re-qualified after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      key_s <= 1'b1;
    end else begin
      sync1 <= key_n;
      key_s <= sync1;
    end
  end

  // The counter holds the number of matching samples already seen, so the
  // DEBOUNCE_CYCLES-th matching sample is the one that finds cnt == CNT_LAST.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      capture_pulse <= 1'b0;
    end else begin
      capture_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (!key_s) begin
            if (cnt == CNT_LAST) begin
              state         <= CAPTURE;
              cnt           <= '0;
              capture_pulse <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt <= '0;
          end
        end
        CAPTURE: begin
          state <= HOLD;
          cnt   <= '0;
        end
        HOLD: begin
          if (key_s) begin
            if (cnt == CNT_LAST) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_acc_stage.sv
// rtl/alu_acc_stage.sv - accumulator stage capturing the ALU result on a debounced key press
//
// Parameters:
//   DEBOUNCE_CYCLES : debounce length in cycles (default 4)
//   HIST_DEPTH      : history entries, fixed at 4
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : alu_acc_stage_if.slave (capture_key, alu_in, hist_sel in;
//             acc_out, capture_pulse, hist_out, hist_count out)
// Build option: define ALU_ACC_HISTORY_EN to build the history buffer; otherwise
// hist_out and hist_count are tied to 0.
module alu_acc_stage
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HIST_DEPTH      = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  alu_acc_stage_if.slave  bus
);

  state_t            state;
  logic              cap_pulse;
  logic [DATA_W-1:0] acc;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clock         (clock),
    .reset_n       (reset_n),
    .key_n         (bus.capture_key),
    .capture_pulse (cap_pulse),
    .state         (state)
  );

  // alu_in is stored verbatim; it is only looked at during the CAPTURE cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (state == CAPTURE) begin
      acc <= bus.alu_in;
    end
  end

  assign bus.acc_out       = acc;
  assign bus.capture_pulse = cap_pulse;

`ifdef ALU_ACC_HISTORY_EN
  logic [DATA_W-1:0] hist [HIST_DEPTH];
  logic [2:0]        hcnt;

  // The value being overwritten by the capture becomes the newest history entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
      hcnt <= '0;
    end else if (state == CAPTURE) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= acc;
      if (hcnt != 3'(HIST_DEPTH)) hcnt <= hcnt + 3'd1;
    end
  end

  assign bus.hist_out   = ({1'b0, bus.hist_sel} < hcnt) ? hist[bus.hist_sel] : '0;
  assign bus.hist_count = hcnt;
`else
  localparam int unused_hist_depth = HIST_DEPTH;
  logic unused_hist_sel;
  assign unused_hist_sel = ^bus.hist_sel;

  assign bus.hist_out   = '0;
  assign bus.hist_count = '0;
`endif

endmodule

// File: tb/tb_alu_acc_stage.sv
// tb/tb_alu_acc_stage.sv - directed self-checking bench for alu_acc_stage
module tb_alu_acc_stage;
  import alu_pkg::*;

`ifdef ALU_ACC_HISTORY_EN
  localparam bit HIST_ON = 1'b1;
`else
  localparam bit HIST_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  alu_acc_stage_if bus ();

  logic [7:0] tb_alu;
  logic       use_alu;
  // Bench model of the ALU in add mode with A = 3 and B = acc_out[3:0].
  assign bus.alu_in = use_alu ? (8'h03 + {4'h0, bus.acc_out[3:0]}) : tb_alu;

  alu_acc_stage #(
    .DEBOUNCE_CYCLES (4),
    .HIST_DEPTH      (4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Key driven at a falling edge: with D=4 the pulse shows after the 6th
  // rising edge and the accumulator holds the new value after the 7th.
  task automatic press(input logic [7:0] v, input logic [7:0] exp, input string tag);
    int lat;
    lat = 99;
    tb_alu = v;
    bus.capture_key = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (bus.capture_pulse) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, lat, 6);
    @(negedge clock);
    check({tag, "_pulse_one_cycle"}, bus.capture_pulse, 1'b0);
    check({tag, "_acc"}, bus.acc_out, exp);
  endtask

  task automatic release_key();
    bus.capture_key = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  int pulses;

  initial begin
    reset_n         = 1'b0;
    bus.capture_key = 1'b1;
    bus.hist_sel    = 2'd0;
    tb_alu          = 8'h00;
    use_alu         = 1'b0;
    #1;
    check("reset_acc", bus.acc_out, 8'h00);
    check("reset_pulse", bus.capture_pulse, 1'b0);
    check("reset_hist_count", bus.hist_count, 3'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Single press, then hold for 100 cycles.
    press(8'h2D, 8'h2D, "single");
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.capture_pulse) pulses++;
    end
    check("held_no_repeat", pulses, 0);

    // Asynchronous reset mid-clock with the key still held.
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_acc", bus.acc_out, 8'h00);
    check("midreset_pulse", bus.capture_pulse, 1'b0);
    check("midreset_hist_count", bus.hist_count, 3'd0);
    @(negedge clock);
    reset_n = 1'b1;
    press(8'h5A, 8'h5A, "requalify");
    release_key();

    // Bounce: 3 low, 1 high, 3 low must not capture.
    pulses = 0;
    tb_alu = 8'hEE;
    for (int i = 0; i < 11; i++) begin
      bus.capture_key = (i == 3 || i >= 7) ? 1'b1 : 1'b0;
      @(negedge clock);
      if (bus.capture_pulse) pulses++;
    end
    check("bounce_no_capture", pulses, 0);
    check("bounce_acc_kept", bus.acc_out, 8'h5A);
    press(8'h77, 8'h77, "after_bounce");
    release_key();

    // History.
    do_reset();
    press(8'h01, 8'h01, "hist1");
    release_key();
    bus.hist_sel = 2'd2;
    #1;
    check("hist_sel_beyond_count", bus.hist_out, 8'h00);
    check("hist_count_one", bus.hist_count, HIST_ON ? 3'd1 : 3'd0);
    press(8'h02, 8'h02, "hist2");
    release_key();
    press(8'h03, 8'h03, "hist3");
    release_key();
    press(8'h04, 8'h04, "hist4");
    release_key();
    press(8'h05, 8'h05, "hist5");
    release_key();
    check("hist_acc", bus.acc_out, 8'h05);
    check("hist_count_sat", bus.hist_count, HIST_ON ? 3'd4 : 3'd0);
    bus.hist_sel = 2'd0; #1;
    check("hist_sel0", bus.hist_out, HIST_ON ? 8'h04 : 8'h00);
    bus.hist_sel = 2'd1; #1;
    check("hist_sel1", bus.hist_out, HIST_ON ? 8'h03 : 8'h00);
    bus.hist_sel = 2'd2; #1;
    check("hist_sel2", bus.hist_out, HIST_ON ? 8'h02 : 8'h00);
    bus.hist_sel = 2'd3; #1;
    check("hist_sel3", bus.hist_out, HIST_ON ? 8'h01 : 8'h00);

    // Feedback loop through the bench ALU model.
    do_reset();
    use_alu = 1'b1;
    press(8'h00, 8'h03, "feedback1");
    release_key();
    press(8'h00, 8'h06, "feedback2");
    release_key();
    press(8'h00, 8'h09, "feedback3");
    release_key();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
